// File: rtl/dram_cmd_timer_if.sv
// Command handshake and DRAM array issue bus for dram_cmd_timer.
interface dram_cmd_timer_if #(
   parameter int unsigned NUM_OF_BANKS = 8,
   parameter int unsigned NUM_OF_ROWS  = 128,
   parameter int unsigned NUM_OF_COLS  = 8
);
   localparam int unsigned BANK_W = $clog2(NUM_OF_BANKS);
   localparam int unsigned ROW_W  = $clog2(NUM_OF_ROWS);
   localparam int unsigned COL_W  = $clog2(NUM_OF_COLS);

   // requester side
   logic                    cmd_req;
   logic [1:0]              cmd;
   logic [NUM_OF_BANKS-1:0] bank_sel;
   logic [NUM_OF_ROWS-1:0]  row_sel;
   logic [NUM_OF_COLS-1:0]  col_sel;
   logic                    cmd_ack;
   logic                    cmd_err;

   // array side
   logic                    dram_cmd_valid;
   logic [1:0]              dram_cmd;
   logic [BANK_W-1:0]       dram_bank;
   logic [ROW_W-1:0]        dram_row;
   logic [COL_W-1:0]        dram_col;
   logic [NUM_OF_BANKS-1:0] bank_open;

   modport master (
      output cmd_req, cmd, bank_sel, row_sel, col_sel,
      input  cmd_ack, cmd_err, dram_cmd_valid, dram_cmd, dram_bank, dram_row, dram_col,
             bank_open
   );

   modport slave (
      input  cmd_req, cmd, bank_sel, row_sel, col_sel,
      output cmd_ack, cmd_err, dram_cmd_valid, dram_cmd, dram_bank, dram_row, dram_col,
             bank_open
   );
endinterface

// File: rtl/dram_cmd_timer.sv
// DRAM command timer: accepts one command at a time, checks bank state and
// tRCD/tRP/tRAS/tCCD, then issues it to the array as a single-cycle pulse.
module dram_cmd_timer #(
   parameter int unsigned NUM_OF_BANKS = 8,
   parameter int unsigned NUM_OF_ROWS  = 128,
   parameter int unsigned NUM_OF_COLS  = 8,
   parameter int unsigned T_RCD        = 4,
   parameter int unsigned T_RP         = 4,
   parameter int unsigned T_RAS        = 10,
   parameter int unsigned T_CCD        = 2
) (
   input logic             clk,
   input logic             rst_b,
   dram_cmd_timer_if.slave bus
);
   localparam int unsigned BANK_W = $clog2(NUM_OF_BANKS);
   localparam int unsigned ROW_W  = $clog2(NUM_OF_ROWS);
   localparam int unsigned COL_W  = $clog2(NUM_OF_COLS);

   localparam logic [1:0] CmdAct = 2'b00;
   localparam logic [1:0] CmdRd  = 2'b01;
   localparam logic [1:0] CmdWr  = 2'b10;
   localparam logic [1:0] CmdPre = 2'b11;

   // Timers are loaded with T-1 because the issue cycle itself counts toward the gap:
   // a timer reads 0 exactly in the first cycle a new issue is legal.
   localparam logic [7:0] LD_RCD = 8'(T_RCD - 1);
   localparam logic [7:0] LD_RP  = 8'(T_RP - 1);
   localparam logic [7:0] LD_RAS = 8'(T_RAS - 1);
   localparam logic [7:0] LD_CCD = 8'(T_CCD - 1);

   typedef enum logic [2:0] {
      StIdle, StCheck, StWait, StIssue, StAck, StAckErr
   } state_e;

   state_e state_q, state_d;

   // captured command
   logic [1:0]        cmd_q;
   logic [BANK_W-1:0] bank_q;
   logic [ROW_W-1:0]  row_q;
   logic [COL_W-1:0]  col_q;
   logic              bank_ok_q, row_ok_q, col_ok_q;

   // encoded selects
   logic [BANK_W-1:0] bank_enc;
   logic [ROW_W-1:0]  row_enc;
   logic [COL_W-1:0]  col_enc;

   // bank state and timers
   logic [NUM_OF_BANKS-1:0]            bank_open_q;
   logic [NUM_OF_BANKS-1:0][ROW_W-1:0] open_row_q;
   logic [NUM_OF_BANKS-1:0][7:0]       rcd_q, ras_q, rp_q;
   logic [7:0]                         ccd_q;

   // issued command fields, held between issues
   logic [1:0]        dram_cmd_q;
   logic [BANK_W-1:0] dram_bank_q;
   logic [ROW_W-1:0]  dram_row_q;
   logic [COL_W-1:0]  dram_col_q;

   logic is_rw, legal, ready, issue, enter_issue;

   // One-hot to binary by OR-ing indices; validity is checked separately.
   always_comb begin
      bank_enc = '0;
      row_enc  = '0;
      col_enc  = '0;
      for (int i = 0; i < NUM_OF_BANKS; i++) if (bus.bank_sel[i]) bank_enc |= BANK_W'(i);
      for (int i = 0; i < NUM_OF_ROWS; i++)  if (bus.row_sel[i])  row_enc  |= ROW_W'(i);
      for (int i = 0; i < NUM_OF_COLS; i++)  if (bus.col_sel[i])  col_enc  |= COL_W'(i);
   end

   // Capture the request and its encoded selects when leaving IDLE.
   always_ff @(posedge clk or negedge rst_b) begin
      if (!rst_b) begin
         cmd_q     <= '0;
         bank_q    <= '0;
         row_q     <= '0;
         col_q     <= '0;
         bank_ok_q <= 1'b0;
         row_ok_q  <= 1'b0;
         col_ok_q  <= 1'b0;
      end else if (state_q == StIdle && bus.cmd_req) begin
         cmd_q     <= bus.cmd;
         bank_q    <= bank_enc;
         row_q     <= row_enc;
         col_q     <= col_enc;
         bank_ok_q <= $onehot(bus.bank_sel);
         row_ok_q  <= $onehot(bus.row_sel);
         col_ok_q  <= $onehot(bus.col_sel);
      end
   end

   // Legality of the captured command and readiness of its governing timers.
   // A timer of 1 here reaches 0 in the cycle the command would issue.
   always_comb begin
      is_rw = (cmd_q == CmdRd) || (cmd_q == CmdWr);
      legal = bank_ok_q;
      ready = 1'b0;
      unique case (cmd_q)
         CmdAct: begin
            legal = legal && row_ok_q && !bank_open_q[bank_q];
            ready = rp_q[bank_q] <= 8'd1;
         end
         CmdRd, CmdWr: begin
            legal = legal && col_ok_q && bank_open_q[bank_q];
            ready = (rcd_q[bank_q] <= 8'd1) && (ccd_q <= 8'd1);
         end
         default: begin
            legal = legal && bank_open_q[bank_q];
            ready = ras_q[bank_q] <= 8'd1;
         end
      endcase
   end

   // Next-state logic.
   always_comb begin
      state_d = state_q;
      unique case (state_q)
         StIdle:   if (bus.cmd_req) state_d = StCheck;
         StCheck:  state_d = !legal ? StAckErr : (ready ? StIssue : StWait);
         StWait:   if (ready) state_d = StIssue;
         StIssue:  state_d = StAck;
         StAck:    state_d = StIdle;
         StAckErr: state_d = StIdle;
         default:  state_d = StIdle;
      endcase
   end

   // State register.
   always_ff @(posedge clk or negedge rst_b) begin
      if (!rst_b) state_q <= StIdle;
      else        state_q <= state_d;
   end

   assign issue       = (state_q == StIssue);
   assign enter_issue = (state_d == StIssue) && (state_q != StIssue);

   // Load the array-side fields on entry to ISSUE so they are valid with the pulse.
   always_ff @(posedge clk or negedge rst_b) begin
      if (!rst_b) begin
         dram_cmd_q  <= '0;
         dram_bank_q <= '0;
         dram_row_q  <= '0;
         dram_col_q  <= '0;
      end else if (enter_issue) begin
         dram_cmd_q  <= cmd_q;
         dram_bank_q <= bank_q;
         dram_row_q  <= (cmd_q == CmdAct) ? row_q : open_row_q[bank_q];
         if (is_rw) dram_col_q <= col_q;
      end
   end

   // Bank open state and open-row table, updated in the issue cycle.
   always_ff @(posedge clk or negedge rst_b) begin
      if (!rst_b) begin
         bank_open_q <= '0;
         open_row_q  <= '0;
      end else if (issue) begin
         if (cmd_q == CmdAct) begin
            bank_open_q[bank_q] <= 1'b1;
            open_row_q[bank_q]  <= row_q;
         end else if (cmd_q == CmdPre) begin
            bank_open_q[bank_q] <= 1'b0;
         end
      end
   end

   // Saturating down-counters; a load at issue overrides the decrement.
   always_ff @(posedge clk or negedge rst_b) begin
      if (!rst_b) begin
         rcd_q <= '0;
         ras_q <= '0;
         rp_q  <= '0;
         ccd_q <= '0;
      end else begin
         for (int b = 0; b < NUM_OF_BANKS; b++) begin
            rcd_q[b] <= (rcd_q[b] != 8'd0) ? rcd_q[b] - 8'd1 : 8'd0;
            ras_q[b] <= (ras_q[b] != 8'd0) ? ras_q[b] - 8'd1 : 8'd0;
            rp_q[b]  <= (rp_q[b]  != 8'd0) ? rp_q[b]  - 8'd1 : 8'd0;
            if (issue && bank_q == BANK_W'(b)) begin
               if (cmd_q == CmdAct) begin
                  rcd_q[b] <= LD_RCD;
                  ras_q[b] <= LD_RAS;
               end
               if (cmd_q == CmdPre) rp_q[b] <= LD_RP;
            end
         end
         ccd_q <= (ccd_q != 8'd0) ? ccd_q - 8'd1 : 8'd0;
         if (issue && is_rw) ccd_q <= LD_CCD;
      end
   end

   assign bus.cmd_ack        = (state_q == StAck) || (state_q == StAckErr);
   assign bus.cmd_err        = (state_q == StAckErr);
   assign bus.dram_cmd_valid = issue;
   assign bus.dram_cmd       = dram_cmd_q;
   assign bus.dram_bank      = dram_bank_q;
   assign bus.dram_row       = dram_row_q;
   assign bus.dram_col       = dram_col_q;
   assign bus.bank_open      = bank_open_q;

endmodule
